alu_scan_harness: RTL
=====================

# alu_scan_harness

- Parametrised serial test harness around the shared `alu` core.
- Shifts a framed command (control bits plus two operands) in over `LANES` parallel serial inputs, runs one ALU evaluation, then shifts the result and compare flags out.
- Sits between the chip-level pin wrapper and `alu`. Generalises the single-lane, free-running scan chain to configurable width and lane count, with a framed FSM, `busy`/`done` handshake and overrun detection.

## Interface
- `XLEN`, 64: ALU operand width; 32 or 64.
- `LANES`, 1: serial lanes per direction; 1, 2, 4 or 8.
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `start`  in  1: frame start; honoured only in IDLE.
- `tdi`  in  LANES: serial command/operand input.
- `tdo`  out  LANES: serial result output.
- `busy`  out  1: high whenever state is not IDLE.
- `done`  out  1: one-cycle pulse coinciding with the last output beat.
- `overrun`  out  1: sticky; set when `start` is seen while `busy`.

## Operation
- Input frame, `IN_BITS = 2*XLEN+6`, LSB-first:
  - bit 0 `sub`, bit 1 `ashr`, bits 2–4 `funct3`, bit 5 `w`;
  - bits 6..XLEN+5 `op1`; next XLEN bits `op2`.
- Output frame, `OUT_BITS = XLEN+3`: bits 0..XLEN-1 `result`, then `eq`, `lt`, `ltu`.
- Beat i, lane k carries frame bit `i*LANES+k`.
- Beat counts: `IN_BEATS = ceil(IN_BITS/LANES)`, `OUT_BEATS = ceil(OUT_BITS/LANES)`.
- Input padding bits beyond `IN_BITS` are ignored. Output padding bits are driven 0.
- FSM states and transitions:
  - IDLE: `start=1` → SHIFT_IN.
  - SHIFT_IN: after beat `IN_BEATS-1` → EXEC.
  - EXEC: one cycle; `result`/flags from `alu` are registered into the output shift register → SHIFT_OUT.
  - SHIFT_OUT: after beat `OUT_BEATS-1` → IDLE.
- `alu` semantics: RISC-V funct3 encoding.
  - `sub` selects subtract for funct3=000.
  - `ashr` selects arithmetic shift for funct3=101.
  - `w` gives a 32-bit operation sign-extended to XLEN; `w` is ignored when XLEN=32.
- `eq`, `lt`, `ltu` always compare `op1` against `op2`, independent of funct3.
- `start` while `busy`: ignored for sequencing; sets `overrun`. `overrun` clears only on reset.
- `start` held high across several IDLE cycles: only the first edge into SHIFT_IN counts. A new frame may start in the cycle after `done`.

## Timing
- Reset (`rst_n=0` at a clock edge):
  - state IDLE, beat counter 0, shift registers 0;
  - `tdo=0`, `busy=0`, `done=0`, `overrun=0`.
- Reset mid-frame aborts the frame; no `done` is produced.
- `start` sampled high in IDLE at cycle T: `tdi` beat 0 is captured at T, beat i at T+i.
- EXEC at T+IN_BEATS.
- `tdo` beat j valid during cycle T+IN_BEATS+1+j, driven from a register.
- `done=1` in cycle T+IN_BEATS+OUT_BEATS only.
- `busy=1` from T+1 through T+IN_BEATS+OUT_BEATS.
- `tdo=0` outside SHIFT_OUT.
- Full-frame latency: `IN_BEATS+OUT_BEATS+1` cycles, start to done inclusive.

## Structure
- Package `alu_scan_pkg` holds:
  - FSM state enum (IDLE, SHIFT_IN, EXEC, SHIFT_OUT);
  - funct3 constants (ADD=000, SLL=001, SLT=010, SLTU=011, XOR=100, SRL=101, OR=110, AND=111);
  - functions `in_beats(XLEN,LANES)` and `out_beats(XLEN,LANES)`.
- One sub-module: the existing combinational `alu #(XLEN)`, instantiated unchanged. FSM, counters and shift registers live in `alu_scan_harness`.
- Beat counter width: `$clog2(IN_BEATS+1)`.

## Test plan
- XLEN=32, LANES=1: add, op1=5, op2=7.
  - IN_BEATS=70, OUT_BEATS=35.
  - result=0x0000000C, eq=0, lt=1, ltu=1; `done` at T+105.
- XLEN=32, LANES=4: sub, op1=3, op2=5.
  - IN_BEATS=18, OUT_BEATS=9.
  - result=0xFFFFFFFE, lt=1, ltu=1.
  - Beat 8 lanes 0–2 = eq/lt/ltu, lane 3 = 0.
- XLEN=64, LANES=2, w=1: add, op1=0x7FFFFFFF, op2=1 → result=0xFFFFFFFF80000000.
  - Also XLEN=64, LANES=2: sra (funct3=101, ashr=1), op1=0x8000000000000000, op2=4 → result=0xF800000000000000.
- `start` pulsed during SHIFT_IN:
  - frame completes with correct result;
  - `overrun=1` and stays high;
  - a second frame started right after `done` is correct.
- `rst_n=0` for one cycle at beat 10 of SHIFT_IN:
  - all outputs 0 next cycle, no `done`;
  - the following fresh frame (and=0xF0F0, 0xFF00) returns 0xF000.
- Back-to-back frames, `start` asserted the cycle after `done`, 8 randomised frames: all match the reference model, `overrun=0`.

Source files
------------

// File: rtl/alu_scan_pkg.sv
// Shared types, funct3 encodings and frame-geometry helpers for the ALU scan harness.
package alu_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_IN,
        EXEC,
        SHIFT_OUT
    } state_t;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] SLL  = 3'b001;
    localparam logic [2:0] SLT  = 3'b010;
    localparam logic [2:0] SLTU = 3'b011;
    localparam logic [2:0] XOR  = 3'b100;
    localparam logic [2:0] SRL  = 3'b101;
    localparam logic [2:0] OR   = 3'b110;
    localparam logic [2:0] AND  = 3'b111;

    // Beats needed to carry a frame, rounding up so a partial last beat still counts.
    function automatic int in_beats(input int xlen, input int lanes);
        return (2 * xlen + 6 + lanes - 1) / lanes;
    endfunction

    function automatic int out_beats(input int xlen, input int lanes);
        return (xlen + 3 + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational RISC-V style ALU with W-form (32-bit, sign-extended) operations
// and funct3-independent eq/lt/ltu compare flags.
module alu
    import alu_scan_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            sub,
    input  logic            ashr,
    input  logic            w,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result,
    output logic            eq,
    output logic            lt,
    output logic            ltu
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] full;
    logic [SHW-1:0]  shamt;
    logic [31:0]     a32;
    logic [31:0]     b32;
    logic [31:0]     r32;

    assign shamt = op2[SHW-1:0];
    assign a32   = op1[31:0];
    assign b32   = op2[31:0];

    assign eq  = (op1 == op2);
    assign lt  = ($signed(op1) < $signed(op2));
    assign ltu = (op1 < op2);

    always_comb begin
        full = '0;
        case (funct3)
            ADD:  full = sub ? (op1 - op2) : (op1 + op2);
            SLL:  full = op1 << shamt;
            SLT:  full = {{(XLEN-1){1'b0}}, lt};
            SLTU: full = {{(XLEN-1){1'b0}}, ltu};
            XOR:  full = op1 ^ op2;
            SRL: begin
                // Kept as separate statements so the arithmetic shift stays signed.
                if (ashr) full = $signed(op1) >>> shamt;
                else      full = op1 >> shamt;
            end
            OR:   full = op1 | op2;
            AND:  full = op1 & op2;
            default: full = '0;
        endcase
    end

    always_comb begin
        r32 = '0;
        case (funct3)
            ADD:  r32 = sub ? (a32 - b32) : (a32 + b32);
            SLL:  r32 = a32 << b32[4:0];
            SLT:  r32 = {31'b0, $signed(a32) < $signed(b32)};
            SLTU: r32 = {31'b0, a32 < b32};
            XOR:  r32 = a32 ^ b32;
            SRL: begin
                if (ashr) r32 = $signed(a32) >>> b32[4:0];
                else      r32 = a32 >> b32[4:0];
            end
            OR:   r32 = a32 | b32;
            AND:  r32 = a32 & b32;
            default: r32 = '0;
        endcase
    end

    if (XLEN > 32) begin : g_wide
        assign result = w ? {{(XLEN-32){r32[31]}}, r32} : full;
    end else begin : g_narrow
        logic unused_w;
        assign unused_w = w ^ (^r32);
        assign result   = full;
    end

endmodule

// File: rtl/alu_scan_harness.sv
// Framed multi-lane serial harness: shifts a command in, runs one ALU evaluation,
// shifts result and compare flags out, with busy/done handshake and sticky overrun.
module alu_scan_harness
    import alu_scan_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LANES-1:0] tdi,
    output logic [LANES-1:0] tdo,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam int IN_BITS   = 2 * XLEN + 6;
    localparam int OUT_BITS  = XLEN + 3;
    localparam int IN_BEATS  = in_beats(XLEN, LANES);
    localparam int OUT_BEATS = out_beats(XLEN, LANES);
    localparam int IN_W      = IN_BEATS * LANES;
    localparam int OUT_W     = OUT_BEATS * LANES;
    localparam int CNT_W     = $clog2(IN_BEATS + 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] beat;
    logic [IN_W-1:0]  in_sr;
    logic [OUT_W-1:0] out_sr;
    logic             last_in;
    logic             last_out;
    logic             capture;
    logic [XLEN-1:0]  alu_result;
    logic             alu_eq;
    logic             alu_lt;
    logic             alu_ltu;
    logic             unused_pad;

    assign last_in  = (beat == CNT_W'(IN_BEATS - 1));
    assign last_out = (beat == CNT_W'(OUT_BEATS - 1));
    assign capture  = ((state == IDLE) && start) || (state == SHIFT_IN);
    assign tdo      = out_sr[LANES-1:0];
    // Padding bits of the last input beat are shifted in but never decoded.
    assign unused_pad = ^in_sr;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = SHIFT_IN;
            end
            SHIFT_IN: begin
                busy = 1'b1;
                if (last_in) next_state = EXEC;
            end
            EXEC: begin
                busy       = 1'b1;
                next_state = SHIFT_OUT;
            end
            SHIFT_OUT: begin
                busy = 1'b1;
                if (last_out) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Beat 0 is captured on the same edge that sees start in IDLE, so the counter
    // enters SHIFT_IN already pointing at beat 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat    <= '0;
            in_sr   <= '0;
            out_sr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (start && (state != IDLE)) overrun <= 1'b1;
            if (capture) in_sr <= {tdi, in_sr[IN_W-1:LANES]};
            case (state)
                IDLE: begin
                    if (start) beat <= CNT_W'(1);
                end
                SHIFT_IN: begin
                    beat <= last_in ? '0 : beat + 1'b1;
                end
                EXEC: begin
                    out_sr <= OUT_W'({alu_ltu, alu_lt, alu_eq, alu_result});
                end
                SHIFT_OUT: begin
                    out_sr <= out_sr >> LANES;
                    beat   <= last_out ? '0 : beat + 1'b1;
                end
                default: beat <= '0;
            endcase
        end
    end

    alu #(.XLEN(XLEN)) u_alu (
        .op1    (in_sr[XLEN+5:6]),
        .op2    (in_sr[2*XLEN+5:XLEN+6]),
        .sub    (in_sr[0]),
        .ashr   (in_sr[1]),
        .w      (in_sr[5]),
        .funct3 (in_sr[4:2]),
        .result (alu_result),
        .eq     (alu_eq),
        .lt     (alu_lt),
        .ltu    (alu_ltu)
    );

endmodule
